// File: rtl/contador_hms.sv
// contador_hms: BCD hh:mm:ss time-of-day counter advanced by every transition of the 1 Hz wave,
// with run gating, a validated parallel load and six active-low seven-segment digit outputs.
module contador_hms #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk_50mhz,
  input  logic       rst_50mhz,
  input  logic       in_1hz,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       tick,
  output logic       load_err,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  // Hour range endpoints: the value shown at reset, the last hour and the hour after it.
  localparam logic [7:0] HhReset = H24 ? 8'h00 : 8'h12;
  localparam logic [7:0] HhLast  = H24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HhFirst = H24 ? 8'h00 : 8'h01;

  logic       sync1_q, sync2_q, prev_q;
  logic       edge_det, advance;
  logic [7:0] hh_q, hh_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       tick_q, tick_d;
  logic       err_q, err_d;
  logic       digits_ok, hh_ok, load_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Two-stage synchroniser plus history flop; both polarities of the wave count as a second.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in_1hz;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ prev_q;
  assign advance  = edge_det & run & ~load;

  always_comb begin
    digits_ok = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
                (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                (load_ss[7:4] <= 4'd9) && (load_ss[3:0] <= 4'd9);
    if (H24) begin
      hh_ok = (load_hh[7:4] < 4'd2) || ((load_hh[7:4] == 4'd2) && (load_hh[3:0] <= 4'd3));
    end else begin
      hh_ok = ((load_hh[7:4] == 4'd0) && (load_hh[3:0] != 4'd0)) ||
              ((load_hh[7:4] == 4'd1) && (load_hh[3:0] <= 4'd2));
    end
    load_ok = digits_ok && hh_ok && (load_mm[7:4] <= 4'd5) && (load_ss[7:4] <= 4'd5);
  end

  // A load cycle swallows any coincident edge, accepted or not.
  always_comb begin
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    tick_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_ok) begin
        hh_d = load_hh;
        mm_d = load_mm;
        ss_d = load_ss;
      end else begin
        err_d = 1'b1;
      end
    end else if (advance) begin
      tick_d = 1'b1;
      if (ss_q == 8'h59) begin
        ss_d = 8'h00;
        if (mm_q == 8'h59) begin
          mm_d = 8'h00;
          hh_d = (hh_q == HhLast) ? HhFirst : bcd_inc(hh_q);
        end else begin
          mm_d = bcd_inc(mm_q);
        end
      end else begin
        ss_d = bcd_inc(ss_q);
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      hh_q   <= HhReset;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign tick     = tick_q;
  assign load_err = err_q;

  assign hex0 = seg7(ss_q[3:0]);
  assign hex1 = seg7(ss_q[7:4]);
  assign hex2 = seg7(mm_q[3:0]);
  assign hex3 = seg7(mm_q[7:4]);
  assign hex4 = seg7(hh_q[3:0]);
  assign hex5 = seg7(hh_q[7:4]);

endmodule

// File: tb/tb_contador_hms.sv
// Self-checking bench for contador_hms: a 24h and a 12h instance share stimulus and are compared
// against an integer hours/minutes/seconds model.
module tb_contador_hms;

  logic       clk_50mhz = 1'b0;
  logic       rst_50mhz;
  logic       in_1hz;
  logic       run;
  logic       load;
  logic [7:0] load_hh, load_mm, load_ss;

  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic       tick24, err24, tick12, err12;
  logic [6:0] h24_0, h24_1, h24_2, h24_3, h24_4, h24_5;
  logic [6:0] h12_0, h12_1, h12_2, h12_3, h12_4, h12_5;

  contador_hms #(.H24(1'b1)) dut24 (
    .clk_50mhz(clk_50mhz), .rst_50mhz(rst_50mhz), .in_1hz(in_1hz), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh24), .mm(mm24), .ss(ss24), .tick(tick24), .load_err(err24),
    .hex0(h24_0), .hex1(h24_1), .hex2(h24_2), .hex3(h24_3), .hex4(h24_4), .hex5(h24_5)
  );

  contador_hms #(.H24(1'b0)) dut12 (
    .clk_50mhz(clk_50mhz), .rst_50mhz(rst_50mhz), .in_1hz(in_1hz), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh12), .mm(mm12), .ss(ss12), .tick(tick12), .load_err(err12),
    .hex0(h12_0), .hex1(h12_1), .hex2(h12_2), .hex3(h12_3), .hex4(h12_4), .hex5(h12_5)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  wire [23:0] t24 = {hh24, mm24, ss24};
  wire [23:0] t12 = {hh12, mm12, ss12};
  wire [41:0] x24 = {h24_5, h24_4, h24_3, h24_2, h24_1, h24_0};
  wire [41:0] x12 = {h12_5, h12_4, h12_3, h12_2, h12_1, h12_0};

  int checks = 0;
  int failures = 0;
  int tick_cnt24 = 0, tick_cnt12 = 0, err_cnt24 = 0, err_cnt12 = 0;

  always @(negedge clk_50mhz) begin
    if (tick24 === 1'b1) tick_cnt24 <= tick_cnt24 + 1;
    if (tick12 === 1'b1) tick_cnt12 <= tick_cnt12 + 1;
    if (err24 === 1'b1) err_cnt24 <= err_cnt24 + 1;
    if (err12 === 1'b1) err_cnt12 <= err_cnt12 + 1;
  end

  // Reference model: plain integer time for each hour mode.
  int m_h24, m_m24, m_s24, m_h12, m_m12, m_s12;

  function automatic logic [7:0] to_b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {to_b(h), to_b(m), to_b(s)};
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] to_hex(input logic [23:0] t);
    return {seg(t[23:20]), seg(t[19:16]), seg(t[15:12]), seg(t[11:8]), seg(t[7:4]), seg(t[3:0])};
  endfunction

  function automatic logic [23:0] exp24();
    return to_bcd(m_h24, m_m24, m_s24);
  endfunction

  function automatic logic [23:0] exp12();
    return to_bcd(m_h12, m_m12, m_s12);
  endfunction

  function automatic int dec(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input bit is24);
    int hv, mv, sv;
    hv = dec(h);
    mv = dec(m);
    sv = dec(s);
    if (hv < 0 || mv < 0 || sv < 0 || mv > 59 || sv > 59) return 1'b0;
    if (is24) return hv <= 23;
    return hv >= 1 && hv <= 12;
  endfunction

  task automatic model_reset();
    m_h24 = 0;  m_m24 = 0; m_s24 = 0;
    m_h12 = 12; m_m12 = 0; m_s12 = 0;
  endtask

  task automatic model_advance();
    m_s24++;
    if (m_s24 == 60) begin
      m_s24 = 0; m_m24++;
      if (m_m24 == 60) begin m_m24 = 0; m_h24 = (m_h24 + 1) % 24; end
    end
    m_s12++;
    if (m_s12 == 60) begin
      m_s12 = 0; m_m12++;
      if (m_m12 == 60) begin m_m12 = 0; m_h12 = m_h12 % 12 + 1; end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic transition();
    in_1hz = ~in_1hz;
    step(3);
    if (run) model_advance();
  endtask

  task automatic drive_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            output logic e24, output logic e12);
    load_hh = h; load_mm = m; load_ss = s;
    load = 1'b1;
    @(posedge clk_50mhz);
    #1;
    e24 = err24;
    e12 = err12;
    load = 1'b0;
    if (valid(h, m, s, 1'b1)) begin m_h24 = dec(h); m_m24 = dec(m); m_s24 = dec(s); end
    if (valid(h, m, s, 1'b0)) begin m_h12 = dec(h); m_m12 = dec(m); m_s12 = dec(s); end
  endtask

  task automatic test_reset();
    rst_50mhz = 1'b0; in_1hz = 1'b0; run = 1'b1; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    step(3);
    checks++;
    if ({t24, t12} !== {24'h000000, 24'h120000}) begin
      failures++; $display("FAIL reset_time got=%h/%h want=000000/120000", t24, t12);
    end
    checks++;
    if (x24 !== {6{7'b1000000}}) begin
      failures++; $display("FAIL reset_hex24 got=%h want=%h", x24, {6{7'b1000000}});
    end
    checks++;
    if ({tick24, err24, tick12, err12} !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses got=%b want=0000", {tick24, err24, tick12, err12});
    end
    rst_50mhz = 1'b1;
    model_reset();
    step(4);
    checks++;
    if ({t24, t12, x12} !== {exp24(), exp12(), to_hex(exp12())}) begin
      failures++; $display("FAIL post_release got=%h/%h want=%h/%h", t24, t12, exp24(), exp12());
    end
  endtask

  task automatic test_first_edge();
    int c24;
    c24 = tick_cnt24;
    in_1hz = 1'b1;
    step(2);
    checks++;
    if ({ss24, tick24} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL early_edge got ss=%h tick=%b want ss=00 tick=0", ss24, tick24);
    end
    step(1);
    model_advance();
    checks++;
    if ({ss24, tick24, h24_0} !== {8'h01, 1'b1, 7'b1111001}) begin
      failures++;
      $display("FAIL first_edge got ss=%h tick=%b hex0=%b want 01 1 1111001", ss24, tick24, h24_0);
    end
    step(1);
    checks++;
    if ({t12, tick24, tick_cnt24 - c24} !== {exp12(), 1'b0, 32'd1}) begin
      failures++;
      $display("FAIL first_tick got t12=%h tick=%b n=%0d want %h 0 1", t12, tick24,
               tick_cnt24 - c24, exp12());
    end
  endtask

  task automatic test_full_carry();
    logic e24, e12;
    int c24;
    drive_load(8'h23, 8'h59, 8'h58, e24, e12);
    checks++;
    if ({e24, e12, t24} !== {1'b0, 1'b1, 24'h235958}) begin
      failures++; $display("FAIL load_235958 got err=%b%b t=%h want err=01 t=235958", e24, e12, t24);
    end
    c24 = tick_cnt24;
    transition();
    checks++;
    if (t24 !== 24'h235959) begin
      failures++; $display("FAIL carry_a got=%h want=235959", t24);
    end
    transition();
    step(1);
    checks++;
    if ({t24, t12, tick_cnt24 - c24} !== {24'h000000, exp12(), 32'd2}) begin
      failures++;
      $display("FAIL carry_b got=%h/%h ticks=%0d want=000000/%h ticks=2", t24, t12,
               tick_cnt24 - c24, exp12());
    end
    drive_load(8'h12, 8'h59, 8'h59, e24, e12);
    transition();
    checks++;
    if ({t12, t24} !== {24'h010000, exp24()}) begin
      failures++; $display("FAIL carry_12h got=%h/%h want=010000/%h", t12, t24, exp24());
    end
  endtask

  task automatic test_invalid_load();
    logic [23:0] bad [3];
    logic e24, e12;
    int c24, c12;
    bad[0] = 24'h240000; bad[1] = 24'h105A00; bad[2] = 24'h003000;
    for (int i = 0; i < 3; i++) begin
      c24 = err_cnt24; c12 = err_cnt12;
      drive_load(bad[i][23:16], bad[i][15:8], bad[i][7:0], e24, e12);
      step(1);
      checks++;
      if ({e24, e12} !== {~valid(bad[i][23:16], bad[i][15:8], bad[i][7:0], 1'b1),
                          ~valid(bad[i][23:16], bad[i][15:8], bad[i][7:0], 1'b0)} ||
          err_cnt24 - c24 != int'(e24) || err_cnt12 - c12 != 1) begin
        failures++;
        $display("FAIL bad_load%0d got err=%b%b n=%0d/%0d", i, e24, e12, err_cnt24 - c24,
                 err_cnt12 - c12);
      end
      checks++;
      if ({t24, t12} !== {exp24(), exp12()}) begin
        failures++; $display("FAIL bad_load_time%0d got=%h/%h want=%h/%h", i, t24, t12,
                             exp24(), exp12());
      end
    end
    drive_load(8'h07, 8'h30, 8'h15, e24, e12);
    checks++;
    if ({e24, x24, t12} !== {1'b0, 7'b1000000, 7'b1111000, 7'b0110000, 7'b1000000, 7'b1111001,
                             7'b0010010, 24'h073015}) begin
      failures++; $display("FAIL load_073015 got err=%b hex=%h t12=%h", e24, x24, t12);
    end
  endtask

  task automatic test_collision();
    logic e24, e12;
    int c24;
    c24 = tick_cnt24;
    in_1hz = ~in_1hz;
    step(2);
    drive_load(8'h10, 8'h00, 8'h00, e24, e12);
    step(2);
    checks++;
    if ({t24, t12, tick_cnt24 - c24} !== {24'h100000, 24'h100000, 32'd0}) begin
      failures++;
      $display("FAIL collision got=%h/%h ticks=%0d want=100000/100000 ticks=0", t24, t12,
               tick_cnt24 - c24);
    end
    transition();
    checks++;
    if ({t24, t12} !== {24'h100001, 24'h100001}) begin
      failures++; $display("FAIL after_collision got=%h/%h want=100001", t24, t12);
    end
  endtask

  task automatic test_run_gating();
    int c24;
    step(1);
    c24 = tick_cnt24;
    run = 1'b0;
    repeat (5) transition();
    checks++;
    if ({t24, t12, tick_cnt24 - c24} !== {exp24(), exp12(), 32'd0}) begin
      failures++; $display("FAIL stopped got=%h ticks=%0d want=%h ticks=0", t24,
                           tick_cnt24 - c24, exp24());
    end
    run = 1'b1;
    step(5);
    checks++;
    if ({t24, tick_cnt24 - c24} !== {exp24(), 32'd0}) begin
      failures++; $display("FAIL no_catchup got=%h ticks=%0d want=%h", t24, tick_cnt24 - c24,
                           exp24());
    end
    transition();
    step(1);
    checks++;
    if ({t24, t12, tick_cnt24 - c24} !== {to_bcd(10, 0, 2), exp12(), 32'd1}) begin
      failures++; $display("FAIL resume got=%h ticks=%0d want=100002 ticks=1", t24,
                           tick_cnt24 - c24);
    end
  endtask

  task automatic test_random();
    logic e24, e12;
    logic [7:0] h, m, s;
    int c24, c12, n_adv;
    c24 = tick_cnt24; c12 = tick_cnt12; n_adv = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          run = ($urandom_range(0, 3) != 0);
          if (run) n_adv++;
          transition();
        end
        2: begin
          if ($urandom_range(0, 1) == 1) begin
            h = to_b($urandom_range(1, 12));
            m = to_b($urandom_range(0, 59));
            s = to_b($urandom_range(55, 59));
          end else begin
            h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
          end
          drive_load(h, m, s, e24, e12);
          checks++;
          if ({e24, e12} !== {~valid(h, m, s, 1'b1), ~valid(h, m, s, 1'b0)}) begin
            failures++; $display("FAIL rand_load_err%0d in=%h%h%h got=%b%b", i, h, m, s, e24, e12);
          end
        end
        default: step($urandom_range(1, 4));
      endcase
      checks++;
      if ({t24, t12, x24, x12} !== {exp24(), exp12(), to_hex(exp24()), to_hex(exp12())}) begin
        failures++;
        $display("FAIL rand%0d got=%h/%h hex=%h/%h want=%h/%h", i, t24, t12, x24, x12,
                 exp24(), exp12());
      end
    end
    run = 1'b1;
    step(1);
    checks++;
    if (tick_cnt24 - c24 != n_adv || tick_cnt12 - c12 != n_adv) begin
      failures++; $display("FAIL rand_ticks got=%0d/%0d want=%0d", tick_cnt24 - c24,
                           tick_cnt12 - c12, n_adv);
    end
  endtask

  task automatic test_async_reset();
    logic e24, e12;
    if (in_1hz == 1'b0) transition();
    drive_load(8'h00, 8'h00, 8'h59, e24, e12);
    step(2);
    @(posedge clk_50mhz);
    #3;
    rst_50mhz = 1'b0;
    #1;
    checks++;
    if ({t24, t12, x24, tick24} !== {24'h000000, 24'h120000, {6{7'b1000000}}, 1'b0}) begin
      failures++; $display("FAIL async_reset got=%h/%h want=000000/120000", t24, t12);
    end
    #9;
    rst_50mhz = 1'b1;
    model_reset();
    // The wave is high at release, so one advance lands three clocks later.
    step(2);
    checks++;
    if ({t24, t12} !== {24'h000000, 24'h120000}) begin
      failures++; $display("FAIL release_early got=%h/%h want=000000/120000", t24, t12);
    end
    step(1);
    model_advance();
    checks++;
    if ({t24, t12, tick24} !== {24'h000001, exp12(), 1'b1}) begin
      failures++; $display("FAIL release_advance got=%h/%h tick=%b want=000001/%h tick=1", t24,
                           t12, tick24, exp12());
    end
    transition();
    checks++;
    if ({t24, t12} !== {24'h000002, exp12()}) begin
      failures++; $display("FAIL post_reset_count got=%h/%h want=000002/%h", t24, t12, exp12());
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_full_carry();
    test_invalid_load();
    test_collision();
    test_run_gating();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
